formant_sched: RTL and testbench

Frame-level controller that sequences the single `formant` engine. It accepts the continuous FFT magnitude stream and forwards exactly one aligned I-beat frame at a time into the engine. It waits for the engine's result (or a watchdog timeout), then pulses the engine's reset so it can take the next frame. Results are returned on a valid/ready port tagged with a frame id, and per-frame drop and timeout statistics are kept.

---
 rtl/formant_pkg.sv | 18 +
 rtl/formant_result_reg.sv | 46 ++++
 rtl/formant_sched.sv | 175 +++++++++++++++++
 tb/tb_formant_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/formant_pkg.sv
// Shared types and helpers for the formant engine frame scheduler.
package formant_pkg;

    typedef enum logic [1:0] {
        RESET_ENG = 2'd0,
        IDLE      = 2'd1,
        FEED      = 2'd2,
        COMPUTE   = 2'd3
    } sched_state_t;

    localparam int FRAME_ID_W = 8;
    localparam int STAT_W     = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/formant_result_reg.sv
// Valid/ready holding register for one engine result and the id of its frame.
module formant_result_reg
    import formant_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int FORMANTS  = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                capture,
    input  logic [FORMANTS:0][BIT_WIDTH-1:0]    cap_freq,
    input  logic [FRAME_ID_W-1:0]               cap_id,
    input  logic                                ready,
    output logic                                valid,
    output logic                                free,
    output logic [FORMANTS:0][BIT_WIDTH-1:0]    freq,
    output logic [FRAME_ID_W-1:0]               frame_id
);

    logic                             valid_r;
    logic [FORMANTS:0][BIT_WIDTH-1:0] freq_r;
    logic [FRAME_ID_W-1:0]            id_r;

    // A capture in the accepting cycle replaces the payload and keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            freq_r  <= '0;
            id_r    <= '0;
        end else if (capture) begin
            valid_r <= 1'b1;
            freq_r  <= cap_freq;
            id_r    <= cap_id;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign free     = !valid_r || ready;
    assign valid    = valid_r;
    assign freq     = freq_r;
    assign frame_id = id_r;

endmodule

// File: rtl/formant_sched.sv
// Frame scheduler: feeds one aligned FFT frame at a time into the formant engine,
// collects its result or aborts on watchdog, then restarts the engine.
module formant_sched
    import formant_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int I          = 160,
    parameter int FORMANTS   = 5,
    parameter int TIMEOUT    = 1000000,
    parameter int RST_CYCLES = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             fft_valid_in,
    input  logic [BIT_WIDTH-1:0]             fft_data_in,
    output logic                             eng_rst_out,
    output logic                             eng_fft_valid_out,
    output logic [BIT_WIDTH-1:0]             eng_fft_data_out,
    input  logic                             eng_formant_valid_in,
    input  logic [FORMANTS:0][BIT_WIDTH-1:0] eng_formant_freq_in,
    output logic                             res_valid_out,
    input  logic                             res_ready_in,
    output logic [FORMANTS:0][BIT_WIDTH-1:0] res_freq_out,
    output logic [FRAME_ID_W-1:0]            res_frame_id_out,
    output logic                             busy_out,
    output logic [STAT_W-1:0]                drop_count_out,
    output logic [STAT_W-1:0]                timeout_count_out
);

    localparam int IN_W = (I > 1) ? $clog2(I) : 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [IN_W-1:0] IN_LAST = IN_W'(I - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    sched_state_t          state_r;
    logic [IN_W-1:0]       in_cnt_r;
    logic [WD_W-1:0]       wd_r;
    logic [RC_W-1:0]       rst_cnt_r;
    logic [FRAME_ID_W-1:0] frame_id_r;
    logic [FRAME_ID_W-1:0] cur_id_r;
    logic [STAT_W-1:0]     drop_r;
    logic [STAT_W-1:0]     tmo_r;
    logic                  eng_rst_r;
    logic                  busy_r;
    logic                  fwd_v_r;
    logic [BIT_WIDTH-1:0]  fwd_d_r;

    logic frame_start_s;
    logic accept_s;
    logic drop_s;
    logic res_free_s;
    logic capture_s;
    logic timeout_s;

    assign frame_start_s = fft_valid_in && (in_cnt_r == {IN_W{1'b0}});
    assign accept_s      = ((state_r == IDLE) && frame_start_s) || ((state_r == FEED) && fft_valid_in);
    assign drop_s        = frame_start_s && (state_r != IDLE);
    assign capture_s     = (state_r == COMPUTE) && eng_formant_valid_in && res_free_s;
    // Watchdog only fires while the engine has nothing to offer; a held result freezes it.
    assign timeout_s     = (state_r == COMPUTE) && !eng_formant_valid_in && (wd_r == WD_LAST);

    // Frame sequencing FSM with registered engine reset and busy flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= RESET_ENG;
            eng_rst_r  <= 1'b1;
            busy_r     <= 1'b0;
            rst_cnt_r  <= '0;
            wd_r       <= '0;
            frame_id_r <= '0;
            cur_id_r   <= '0;
        end else begin
            case (state_r)
                RESET_ENG: begin
                    if (rst_cnt_r == RC_LAST) begin
                        state_r   <= IDLE;
                        eng_rst_r <= 1'b0;
                        busy_r    <= 1'b0;
                        rst_cnt_r <= '0;
                    end else begin
                        busy_r    <= 1'b1;
                        rst_cnt_r <= rst_cnt_r + RC_W'(1);
                    end
                end
                IDLE: begin
                    if (frame_start_s) begin
                        state_r    <= (I == 1) ? COMPUTE : FEED;
                        busy_r     <= 1'b1;
                        wd_r       <= '0;
                        frame_id_r <= frame_id_r + 8'd1;
                        cur_id_r   <= frame_id_r + 8'd1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                FEED: begin
                    if (fft_valid_in && (in_cnt_r == IN_LAST)) begin
                        state_r <= COMPUTE;
                        wd_r    <= '0;
                    end else begin
                        wd_r <= '0;
                    end
                end
                COMPUTE: begin
                    if (capture_s || timeout_s) begin
                        state_r   <= RESET_ENG;
                        eng_rst_r <= 1'b1;
                        rst_cnt_r <= '0;
                    end else if (!eng_formant_valid_in) begin
                        wd_r <= wd_r + WD_W'(1);
                    end else begin
                        wd_r <= wd_r;
                    end
                end
                default: begin
                    state_r   <= RESET_ENG;
                    eng_rst_r <= 1'b1;
                    busy_r    <= 1'b1;
                    rst_cnt_r <= '0;
                end
            endcase
        end
    end

    // Beat alignment counter, forward register and saturating statistics.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            in_cnt_r <= '0;
            fwd_v_r  <= 1'b0;
            fwd_d_r  <= '0;
            drop_r   <= '0;
            tmo_r    <= '0;
        end else begin
            if (fft_valid_in) begin
                in_cnt_r <= (in_cnt_r == IN_LAST) ? {IN_W{1'b0}} : in_cnt_r + IN_W'(1);
            end else begin
                in_cnt_r <= in_cnt_r;
            end
            fwd_v_r <= accept_s;
            if (accept_s) begin
                fwd_d_r <= fft_data_in;
            end else begin
                fwd_d_r <= fwd_d_r;
            end
            drop_r <= drop_s ? sat_inc(drop_r) : drop_r;
            tmo_r  <= timeout_s ? sat_inc(tmo_r) : tmo_r;
        end
    end

    formant_result_reg #(
        .BIT_WIDTH(BIT_WIDTH),
        .FORMANTS (FORMANTS)
    ) u_result (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .capture (capture_s),
        .cap_freq(eng_formant_freq_in),
        .cap_id  (cur_id_r),
        .ready   (res_ready_in),
        .valid   (res_valid_out),
        .free    (res_free_s),
        .freq    (res_freq_out),
        .frame_id(res_frame_id_out)
    );

    assign eng_rst_out       = eng_rst_r;
    assign eng_fft_valid_out = fwd_v_r;
    assign eng_fft_data_out  = fwd_d_r;
    assign busy_out          = busy_r;
    assign drop_count_out    = drop_r;
    assign timeout_count_out = tmo_r;

endmodule

// File: tb/tb_formant_sched.sv
// Bench for formant_sched: engine model, forwarded-beat checker and result scoreboard.
module tb_formant_sched;

    localparam int BW  = 32;
    localparam int I   = 160;
    localparam int NF  = 5;
    localparam int TMO = 1000;
    localparam int RC  = 2;

    typedef logic [NF:0][BW-1:0] freq_t;
    typedef struct {
        logic [7:0] id;
        freq_t      freq;
    } exp_res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fft_valid;
    logic [BW-1:0] fft_data;
    logic          eng_rst;
    logic          eng_fft_valid;
    logic [BW-1:0] eng_fft_data;
    logic          eng_valid;
    freq_t         eng_freq;
    logic          res_valid;
    logic          res_ready;
    freq_t         res_freq;
    logic [7:0]    res_id;
    logic          busy;
    logic [15:0]   drop_cnt;
    logic [15:0]   tmo_cnt;

    int       checks = 0;
    int       passes = 0;
    exp_res_t res_q[$];
    exp_res_t res_e;
    logic     tb_acc = 1'b0;
    int       eng_lat = -1;

    always #5 clk = ~clk;

    formant_sched #(
        .BIT_WIDTH(BW), .I(I), .FORMANTS(NF), .TIMEOUT(TMO), .RST_CYCLES(RC)
    ) dut (
        .clk_in              (clk),
        .rst_n_in            (rst_n),
        .fft_valid_in        (fft_valid),
        .fft_data_in         (fft_data),
        .eng_rst_out         (eng_rst),
        .eng_fft_valid_out   (eng_fft_valid),
        .eng_fft_data_out    (eng_fft_data),
        .eng_formant_valid_in(eng_valid),
        .eng_formant_freq_in (eng_freq),
        .res_valid_out       (res_valid),
        .res_ready_in        (res_ready),
        .res_freq_out        (res_freq),
        .res_frame_id_out    (res_id),
        .busy_out            (busy),
        .drop_count_out      (drop_cnt),
        .timeout_count_out   (tmo_cnt)
    );

    function automatic freq_t exp_freq(input int id);
        freq_t f;
        for (int k = 0; k <= NF; k++) f[k] = {16'(id), 16'(k)};
        return f;
    endfunction

    // Engine model: counts I forwarded beats, answers eng_lat cycles later, sticky until reset.
    int m_beats, m_delay, m_seq;
    logic m_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_beats <= 0; m_delay <= 0; m_seq <= 0; m_busy <= 1'b0;
            eng_valid <= 1'b0; eng_freq <= '0;
        end else if (eng_rst) begin
            m_beats <= 0; m_busy <= 1'b0; eng_valid <= 1'b0;
        end else begin
            if (eng_fft_valid) begin
                if (m_beats == I - 1) begin
                    m_beats <= 0; m_busy <= 1'b1; m_delay <= 0; m_seq <= m_seq + 1;
                end else begin
                    m_beats <= m_beats + 1;
                end
            end
            if (m_busy) begin
                if (eng_lat >= 0 && m_delay == eng_lat) begin
                    eng_valid <= 1'b1;
                    m_busy    <= 1'b0;
                    eng_freq  <= exp_freq(m_seq);
                end
                m_delay <= m_delay + 1;
            end
        end
    end

    logic          exp_v;
    logic [BW-1:0] exp_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_v <= 1'b0; exp_d <= '0;
        end else begin
            exp_v <= fft_valid && tb_acc;
            exp_d <= fft_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (exp_v || eng_fft_valid)) begin
            checks++;
            if (eng_fft_valid !== exp_v || (exp_v && eng_fft_data !== exp_d))
                $display("FAIL fwd_beat t=%0t: valid=%b data=%h required valid=%b data=%h",
                         $time, eng_fft_valid, eng_fft_data, exp_v, exp_d);
            else passes++;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid && res_ready) begin
            checks++;
            if (res_q.size() == 0) begin
                $display("FAIL res_unexpected t=%0t: id=%0d delivered, required no result", $time, res_id);
            end else begin
                res_e = res_q.pop_front();
                if (res_id !== res_e.id || res_freq !== res_e.freq)
                    $display("FAIL res_payload t=%0t: id=%0d freq0=%h required id=%0d freq0=%h",
                             $time, res_id, res_freq[0], res_e.id, res_e.freq[0]);
                else passes++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int nbeats, input bit acc, input int gap_every);
        for (int b = 0; b < nbeats; b++) begin
            fft_valid = 1'b1; fft_data = $urandom; tb_acc = acc;
            tick(1);
            if (gap_every > 0 && (b % gap_every) == gap_every - 1 && b != nbeats - 1) begin
                fft_valid = 1'b0; tb_acc = 1'b0;
                tick(3);
            end
        end
        fft_valid = 1'b0; tb_acc = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || eng_rst) && n < 5000) begin tick(1); n++; end
        checks++;
        if (busy || eng_rst) $display("FAIL %s_idle: busy=%b eng_rst=%b, required both 0", tag, busy, eng_rst);
        else passes++;
    endtask

    task automatic wait_results(input string tag);
        int n = 0;
        while (res_q.size() > 0 && n < 5000) begin tick(1); n++; end
        checks++;
        if (res_q.size() != 0) $display("FAIL %s_results: %0d outstanding, required 0", tag, res_q.size());
        else passes++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; fft_valid = 1'b0; tb_acc = 1'b0; res_ready = 1'b1; eng_lat = -1;
        res_q.delete();
        tick(2);
        rst_n = 1'b1;
        wait_idle("apply_reset");
    endtask

    task automatic test_reset();
        logic [3:0] hist;
        rst_n = 1'b1; fft_valid = 1'b0; fft_data = '0; res_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (eng_rst !== 1'b1) $display("FAIL reset_eng_rst: %b, required 1", eng_rst); else passes++;
        checks++;
        if ({busy, res_valid, eng_fft_valid, drop_cnt, tmo_cnt, res_id} !== '0 || res_freq !== '0)
            $display("FAIL reset_outputs: busy=%b rv=%b fv=%b drop=%0d tmo=%0d id=%0d, required all 0",
                     busy, res_valid, eng_fft_valid, drop_cnt, tmo_cnt, res_id);
        else passes++;
        fft_valid = 1'b1; tick(3); fft_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin @(negedge clk); hist[k] = eng_rst; end
        checks++;
        if (hist !== 4'b0011) $display("FAIL reset_release_pulse: eng_rst history=%b, required 0011", hist);
        else passes++;
        tick(1);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: %b, required 0", busy); else passes++;
    endtask

    task automatic test_single_frame();
        int n;
        int cnt;
        apply_reset();
        eng_lat = 500;
        res_q.push_back('{id: 8'd1, freq: exp_freq(1)});
        send_frame(I, 1'b1, 40);
        checks++;
        if (busy !== 1'b1 || drop_cnt !== 16'd0) $display("FAIL single_busy: busy=%b drop=%0d, required 1/0", busy, drop_cnt);
        else passes++;
        n = 0;
        do begin @(negedge clk); n++; end while (!eng_valid && n < 2000);
        checks++;
        if (eng_valid !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL single_eng_valid: eng_valid=%b res_valid=%b, required 1/0", eng_valid, res_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || eng_rst !== 1'b1)
            $display("FAIL single_capture: res_valid=%b eng_rst=%b, required 1/1", res_valid, eng_rst);
        else passes++;
        cnt = 1;
        repeat (4) begin @(negedge clk); if (eng_rst) cnt++; end
        checks++;
        if (cnt != RC) $display("FAIL single_rst_pulse: %0d cycles, required %0d", cnt, RC); else passes++;
        checks++;
        if (res_valid !== 1'b0) $display("FAIL single_consumed: res_valid=%b, required 0", res_valid); else passes++;
        tick(1);
        wait_results("single");
        wait_idle("single");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        eng_lat = 400;
        res_q.push_back('{id: 8'd1, freq: exp_freq(1)});
        send_frame(I, 1'b1, 0);
        send_frame(I, 1'b0, 0);
        send_frame(I, 1'b0, 0);
        checks++;
        if (drop_cnt !== 16'd2) $display("FAIL b2b_drops: %0d, required 2", drop_cnt); else passes++;
        wait_results("b2b");
        wait_idle("b2b");
        checks++;
        if (drop_cnt !== 16'd2 || tmo_cnt !== 16'd0)
            $display("FAIL b2b_stats: drop=%0d tmo=%0d, required 2/0", drop_cnt, tmo_cnt);
        else passes++;
    endtask

    task automatic test_timeout();
        int cyc = 0;
        apply_reset();
        send_frame(I, 1'b1, 0);
        do begin tick(1); cyc++; end while (!eng_rst && cyc < 2000);
        checks++;
        if (cyc != TMO) $display("FAIL timeout_cycles: abort after %0d, required %0d", cyc, TMO); else passes++;
        checks++;
        if (tmo_cnt !== 16'd1 || res_valid !== 1'b0)
            $display("FAIL timeout_count: tmo=%0d res_valid=%b, required 1/0", tmo_cnt, res_valid);
        else passes++;
        wait_idle("timeout");
        eng_lat = 50;
        res_q.push_back('{id: 8'd2, freq: exp_freq(2)});
        send_frame(I, 1'b1, 0);
        wait_results("timeout_next");
        wait_idle("timeout_next");
        checks++;
        if (tmo_cnt !== 16'd1 || drop_cnt !== 16'd0)
            $display("FAIL timeout_stats: tmo=%0d drop=%0d, required 1/0", tmo_cnt, drop_cnt);
        else passes++;
    endtask

    task automatic test_ready_hold();
        int n = 0;
        apply_reset();
        res_ready = 1'b0;
        eng_lat = 20;
        res_q.push_back('{id: 8'd1, freq: exp_freq(1)});
        res_q.push_back('{id: 8'd2, freq: exp_freq(2)});
        send_frame(I, 1'b1, 0);
        while (!res_valid && n < 2000) begin tick(1); n++; end
        wait_idle("hold_first");
        send_frame(I, 1'b1, 0);
        tick(1200);
        checks++;
        if (busy !== 1'b1 || tmo_cnt !== 16'd0 || res_valid !== 1'b1)
            $display("FAIL hold_wait: busy=%b tmo=%0d res_valid=%b, required 1/0/1", busy, tmo_cnt, res_valid);
        else passes++;
        checks++;
        if (res_id !== 8'd1 || res_freq !== exp_freq(1))
            $display("FAIL hold_stable: id=%0d freq0=%h, required id=1", res_id, res_freq[0]);
        else passes++;
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        checks++;
        if (eng_rst !== 1'b1) $display("FAIL hold_replace_rst: eng_rst=%b, required 1", eng_rst); else passes++;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_id !== 8'd2)
            $display("FAIL hold_replace: res_valid=%b id=%0d, required 1/2", res_valid, res_id);
        else passes++;
        tick(1);
        res_ready = 1'b1;
        wait_results("hold");
        wait_idle("hold");
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        eng_lat = 30;
        send_frame(80, 1'b1, 0);
        fft_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (eng_fft_valid !== 1'b0 || busy !== 1'b0 || eng_rst !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL midrst_clear: fv=%b busy=%b eng_rst=%b rv=%b, required 0/0/1/0",
                     eng_fft_valid, busy, eng_rst, res_valid);
        else passes++;
        tick(3);
        fft_valid = 1'b0;
        rst_n = 1'b1;
        wait_idle("midrst");
        res_q.push_back('{id: 8'd1, freq: exp_freq(1)});
        send_frame(I, 1'b1, 0);
        wait_results("midrst");
        wait_idle("midrst_done");
        checks++;
        if (drop_cnt !== 16'd0) $display("FAIL midrst_drops: %0d, required 0", drop_cnt); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_timeout();
        test_ready_hold();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: bench did not complete, required completion");
        $fatal(1);
    end

endmodule
